// File: rtl/ifetch_if.sv
// Fetch-side bundle: instruction memory port, redirect request, decode handshake, error flag.
// master = fetch unit, slave = surrounding core (memory, branch unit, decode).
interface ifetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_err;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, fetch_err,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, fetch_err,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch into a 2-entry {pc, instr} buffer; first entry valid one cycle after reset/redirect.
// out_ready low fills the buffer and then freezes the fetch PC; redirects flush and win over fetch.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  ifetch_if.master bus
);
  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [31:0] pc;
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        fetch_err_q;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        pop;
  logic        push;

  assign bus.out_valid = (count != 2'd0);
  assign pop           = bus.out_valid & bus.out_ready;
  // A pop frees a slot in the same cycle, so a full buffer still accepts a fetch when drained.
  assign push          = !bus.redirect_valid & ((count < FULL) | pop);

  assign bus.imem_addr = pc;
  assign bus.out_pc    = buf_pc[rd_ptr];
  assign bus.out_instr = buf_instr[rd_ptr];
  assign bus.fetch_err = fetch_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Any coinciding pop has already been taken by decode; the rest is discarded.
      pc     <= {bus.redirect_pc[31:2], 2'b00};
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        fetch_err_q <= 1'b1;
      end
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= pc;
      buf_instr[wr_ptr] <= bus.imem_instr;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: per-cycle vector table plus a scoreboard of the expected fetch stream,
// with a wrap-around instance and an asynchronous reset pulse sequence.
module tb_ifetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ifetch_if bus ();
  ifetch_if bus2 ();

  ifetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus.imem_instr      = word(bus.imem_addr);
  assign bus2.imem_instr     = word(bus2.imem_addr);
  assign bus2.redirect_valid = 1'b0;
  assign bus2.redirect_pc    = 32'h0;
  assign bus2.out_ready      = 1'b1;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic e_vld, input logic [31:0] e_pc,
                              input logic [31:0] e_addr, input logic e_err);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_vld = e_vld; v.e_pc = e_pc; v.e_addr = e_addr; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic refill(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // Every accepted entry must be the next address of the expected stream.
  task automatic monitor(input logic rv, input logic [31:0] rpc);
    logic [31:0] e;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty: got pop of pc %h, expected no output", bus.out_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", bus.out_pc, e);
        check("sb_instr", bus.out_instr, word(e));
      end
    end
    if (rv) refill({rpc[31:2], 2'b00});
  endtask

  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    #1;
    monitor(rv, rpc);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;

    // stall 5 cycles, drain, fill, redirect when full, misaligned redirect, back-to-back redirects
    tbl.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b0));
    tbl.push_back(mk(1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h4,   1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   32'h8,   1'b0));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h8,   1'b0));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'hC,   1'b0));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   32'h10,  1'b0));
    tbl.push_back(mk(1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   32'h14,  1'b0));
    tbl.push_back(mk(1'b1, 32'h40,  1'b0, 1'b1, 32'hC,   32'h14,  1'b0));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h40,  1'b0));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  32'h44,  1'b0));
    tbl.push_back(mk(1'b1, 32'h42,  1'b1, 1'b1, 32'h44,  32'h48,  1'b0));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h40,  1'b1));
    tbl.push_back(mk(1'b1, 32'h100, 1'b1, 1'b1, 32'h40,  32'h44,  1'b1));
    tbl.push_back(mk(1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   32'h100, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h200, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'h204, 1'b1));
    tbl.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 32'h208, 1'b1));

    refill(32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_vld", 32'(bus.out_valid), 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_err", 32'(bus.fetch_err), 32'h0);
    check("rst_wrap_addr", bus2.imem_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      check($sformatf("vld[%0d]", i), 32'(bus.out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        check($sformatf("pc[%0d]", i), bus.out_pc, tbl[i].e_pc);
        check($sformatf("instr[%0d]", i), bus.out_instr, word(tbl[i].e_pc));
      end
      check($sformatf("addr[%0d]", i), bus.imem_addr, tbl[i].e_addr);
      check($sformatf("err[%0d]", i), 32'(bus.fetch_err), 32'(tbl[i].e_err));
    end

    // Fill the buffer, then pulse reset between clock edges.
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("full_vld", 32'(bus.out_valid), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_vld", 32'(bus.out_valid), 32'h0);
    check("async_addr", bus.imem_addr, 32'h0);
    check("async_err", 32'(bus.fetch_err), 32'h0);
    check("async_wrap_vld", 32'(bus2.out_valid), 32'h0);
    #1 rst_n = 1'b1;
    refill(32'h0);

    step(1'b0, 32'h0, 1'b1);
    check("post_vld", 32'(bus.out_valid), 32'h0);
    check("post_addr", bus.imem_addr, 32'h0);
    check("wrap_vld0", 32'(bus2.out_valid), 32'h0);
    check("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check($sformatf("post_pc%0d", i), bus.out_pc, 32'(4 * i));
      check($sformatf("wrap_vld%0d", i + 1), 32'(bus2.out_valid), 32'h1);
      check($sformatf("wrap_pc%0d", i + 1), bus2.out_pc, 32'hFFFF_FFF8 + 32'(4 * i));
      check($sformatf("wrap_instr%0d", i + 1), bus2.out_instr, word(32'hFFFF_FFF8 + 32'(4 * i)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001: Parameter RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002: Parameter BUF_DEPTH, 2, entries in the fetch buffer; only 2 is supported.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: imem_addr  output  32  byte address presented to instruction memory.
REQ-006: imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007: redirect_valid  input  1  request to restart fetch at redirect_pc (branch/jump/trap).
REQ-008: redirect_pc  input  32  byte target address of the redirect.
REQ-009: out_valid  output  1  head buffer entry is valid for decode.
REQ-010: out_ready  input  1  decode accepts the head entry this cycle.
REQ-011: out_pc  output  32  byte PC of the head entry.
REQ-012: out_instr  output  32  instruction word of the head entry.
REQ-013: fetch_err  output  1  sticky flag, misaligned redirect seen.

Function
REQ-014: Internal fetch PC register pc; imem_addr SHALL equal pc combinationally, and pc[1:0] SHALL always be 2'b00.
REQ-015: Buffer is a 2-entry FIFO of {pc, instr} with read/write pointers and a 0..2 occupancy count; pointers wrap 1 -> 0.
REQ-016: pop = out_valid & out_ready; push = !redirect_valid & (count < 2 | pop).
REQ-017: On push, {pc, imem_instr} is written at the write pointer and pc <= pc + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-018: No push means pc holds and imem_addr is unchanged.
REQ-019: Simultaneous push and pop when count = 2 is legal; count stays 2 and no entry is lost.
REQ-020: out_valid = (count != 0); out_pc/out_instr come from the read-pointer entry with no combinational path from imem_instr.
REQ-021: While out_valid = 1 and out_ready = 0, out_pc and out_instr SHALL hold stable.
REQ-022: Redirect has priority. On a cycle with redirect_valid = 1: count <= 0, both pointers <= 0, pc <= {redirect_pc[31:2], 2'b00}, and no push.
REQ-023: A pop coinciding with a redirect completes; the consumer owns that entry, and the remaining entries are discarded.
REQ-024: Redirect latency: redirect in cycle N gives imem_addr = target in N+1, out_valid = 0 in N+1, and out_valid = 1 with out_pc = target in N+2.
REQ-025: If redirect_pc[1:0] != 0 during redirect_valid, fetch_err <= 1 and stays set until reset; fetch continues at the aligned address.
REQ-026: Back-to-back redirects: each cycle's redirect overrides the previous; only the last target is fetched.
REQ-027: Steady state with out_ready held 1: one instruction per cycle, consecutive out_pc values differ by 4.

Reset
REQ-028: rst_n low asynchronously forces pc = RESET_PC, count = 0, pointers = 0, fetch_err = 0, out_valid = 0, with no clock needed.
REQ-029: out_pc/out_instr are don't-care while out_valid = 0; buffer storage needs no reset.
REQ-030: First cycle after rst_n rises: imem_addr = RESET_PC, out_valid = 0. Next cycle: out_valid = 1, out_pc = RESET_PC.
REQ-031: Reset asserted mid-operation discards all buffered entries and any pending redirect.

Verification
REQ-032: Reset release, out_ready = 1, imem preloaded with word i = 0x1000_0000+i -> out_pc 0x0, 0x4, 0x8, ... one per cycle, with out_instr matching.
REQ-033: out_ready = 0 for 5 cycles after first valid -> count reaches 2 and pc stops at 0x8; out_pc = 0x0 is held stable; after release, entries 0x0, 0x4, 0x8 are seen with no gap or duplicate.
REQ-034: Redirect to 0x40 in cycle N with the buffer full -> out_valid = 0 at N+1; out_pc = 0x40 at N+2; no pre-redirect PC appears afterwards.
REQ-035: Redirect to 0x42 -> fetch_err = 1 thereafter; next out_pc = 0x40.
REQ-036: RESET_PC = 32'hFFFF_FFF8, out_ready = 1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037: rst_n pulsed low between clock edges with the buffer full -> out_valid drops immediately, then the REQ-030 sequence repeats.
